// File: rtl/vpd_cap_bridge_if.sv
// Host-side capability bus and wrapper-side cfg_vpd bus for vpd_cap_bridge.
// vpd_cap_if: slave = bridge, master = config decode; vpd_cfg_if: master = bridge, slave = wrapper.
interface vpd_cap_if;
  logic        cap_addr_we;
  logic [14:0] cap_addr_wdata;
  logic        cap_flag_wdata;
  logic        cap_data_we;
  logic [31:0] cap_data_wdata;
  logic        cap_status_clr;
  logic [14:0] cap_vpd_addr;
  logic        cap_vpd_flag;
  logic [31:0] cap_vpd_data;
  logic        cap_busy;
  logic [3:0]  cap_status;

  modport master (
    output cap_addr_we, cap_addr_wdata, cap_flag_wdata,
    output cap_data_we, cap_data_wdata, cap_status_clr,
    input  cap_vpd_addr, cap_vpd_flag, cap_vpd_data,
    input  cap_busy, cap_status
  );

  modport slave (
    input  cap_addr_we, cap_addr_wdata, cap_flag_wdata,
    input  cap_data_we, cap_data_wdata, cap_status_clr,
    output cap_vpd_addr, cap_vpd_flag, cap_vpd_data,
    output cap_busy, cap_status
  );
endinterface

interface vpd_cfg_if;
  logic [14:0] cfg_vpd_addr;
  logic        cfg_vpd_wren;
  logic [31:0] cfg_vpd_wdata;
  logic        cfg_vpd_rden;
  logic [31:0] vpd_cfg_rdata;
  logic        vpd_cfg_done;
  logic        vpd_err_unimplemented_addr;

  modport master (
    output cfg_vpd_addr, cfg_vpd_wren, cfg_vpd_wdata, cfg_vpd_rden,
    input  vpd_cfg_rdata, vpd_cfg_done, vpd_err_unimplemented_addr
  );

  modport slave (
    input  cfg_vpd_addr, cfg_vpd_wren, cfg_vpd_wdata, cfg_vpd_rden,
    output vpd_cfg_rdata, vpd_cfg_done, vpd_err_unimplemented_addr
  );
endinterface

// File: rtl/vpd_cap_bridge.sv
// VPD capability register writes -> level-held cfg_vpd_* request, one outstanding, timeout + sticky status.
// Ports: clock_afu, reset_afu_n (async low), cap (vpd_cap_if.slave), cfg (vpd_cfg_if.master). Option: VPD_WRITE_PROTECT_EN.
module vpd_cap_bridge #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          TO_WIDTH       = 16,
  parameter logic [14:0] WP_LIMIT       = 15'h0100
) (
  input  logic     clock_afu,
  input  logic     reset_afu_n,
  vpd_cap_if.slave cap,
  vpd_cfg_if.master cfg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TO_WIDTH-1:0] cnt_q;
  logic [14:0] addr_q;
  logic        flag_q;
  logic [31:0] data_q;
  logic [3:0]  st_q;
  logic [3:0]  st_set;
  logic        rden_q, rden_d;
  logic        wren_q, wren_d;

  logic busy, start, finish;
  logic fin_done, fin_to, fin_wp;
  logic wp_new, wp_cur;

`ifdef VPD_WRITE_PROTECT_EN
  logic wp_q;

  assign wp_new = cap.cap_addr_wdata < WP_LIMIT;
  assign wp_cur = wp_q;

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      wp_q <= 1'b0;
    end else if (start) begin
      wp_q <= cap.cap_flag_wdata & wp_new;
    end
  end
`else
  logic unused_wp;

  assign unused_wp = ^WP_LIMIT;
  assign wp_new    = 1'b0;
  assign wp_cur    = 1'b0;
`endif

  assign busy  = (state_q != IDLE);
  assign start = !busy && cap.cap_addr_we;

  // A protected write finishes on its first wait cycle and ignores done.
  assign fin_wp   = (state_q == WR_WAIT) && wp_cur;
  assign fin_done = busy && !fin_wp && cfg.vpd_cfg_done;
  assign fin_to   = busy && !fin_wp && !cfg.vpd_cfg_done &&
                    (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign finish   = fin_wp || fin_done || fin_to;

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = cap.cap_flag_wdata ? WR_WAIT : RD_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (finish) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rden_d = (state_d == RD_WAIT);
    wren_d = (state_d == WR_WAIT) && !(start ? wp_new : wp_cur);
    st_set = {fin_wp,
              busy && (cap.cap_addr_we || cap.cap_data_we),
              fin_to,
              fin_done && cfg.vpd_err_unimplemented_addr};
  end

  always_ff @(posedge clock_afu or negedge reset_afu_n) begin
    if (!reset_afu_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      flag_q <= 1'b0;
      data_q <= '0;
      st_q   <= '0;
      rden_q <= 1'b0;
      wren_q <= 1'b0;
    end else begin
      rden_q <= rden_d;
      wren_q <= wren_d;
      // set wins over clear
      st_q   <= (st_q & ~{4{cap.cap_status_clr}}) | st_set;
      if (start) begin
        cnt_q <= '0;
      end else if (busy) begin
        cnt_q <= cnt_q + TO_WIDTH'(1);
      end
      if (!busy && cap.cap_data_we) begin
        data_q <= cap.cap_data_wdata;
      end
      if (start) begin
        addr_q <= cap.cap_addr_wdata;
        flag_q <= cap.cap_flag_wdata;
      end
      if (finish) begin
        flag_q <= (state_q == RD_WAIT);
      end
      if (finish && state_q == RD_WAIT) begin
        data_q <= (fin_to || cfg.vpd_err_unimplemented_addr) ?
                  32'hFFFF_FFFF : cfg.vpd_cfg_rdata;
      end
    end
  end

  assign cap.cap_vpd_addr  = addr_q;
  assign cap.cap_vpd_flag  = flag_q;
  assign cap.cap_vpd_data  = data_q;
  assign cap.cap_busy      = busy;
  assign cap.cap_status    = st_q;
  assign cfg.cfg_vpd_addr  = addr_q;
  assign cfg.cfg_vpd_wdata = data_q;
  assign cfg.cfg_vpd_rden  = rden_q;
  assign cfg.cfg_vpd_wren  = wren_q;

endmodule

// File: tb/tb_vpd_cap_bridge.sv
// Self-checking bench for vpd_cap_bridge: vector table + scoreboard queue, plus corner sequences.
// Wrapper responses are modelled inline; TIMEOUT_CYCLES is 16.
module tb_vpd_cap_bridge;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vpd_cap_if cap_if ();
  vpd_cfg_if cfg_if ();

  vpd_cap_bridge #(
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH(16),
    .WP_LIMIT(15'h0100)
  ) dut (
    .clock_afu(clk),
    .reset_afu_n(rst_n),
    .cap(cap_if),
    .cfg(cfg_if)
  );

  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [31:0] wdata;
    bit          same;
    int          dly;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] e_data;
    bit          e_flag;
    logic [3:0]  e_st;
    int          e_hold;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          flag;
    logic [3:0]  st;
    int          hold;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;

  function automatic vec_t mk(bit wr, logic [14:0] a, logic [31:0] wd,
                              bit same, int dly, bit err,
                              logic [31:0] rd, logic [31:0] ed, bit ef,
                              logic [3:0] es, int eh);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd; v.same = same;
    v.dly = dly; v.err = err; v.rdata = rd; v.e_data = ed;
    v.e_flag = ef; v.e_st = es; v.e_hold = eh;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int hold, wrong;
    bit ended;
    if (v.wr) begin
      cap_if.cap_data_we = 1'b1;
      cap_if.cap_data_wdata = v.same ? 32'hAAAA_5555 : v.wdata;
      tick();
      cap_if.cap_data_we = 1'b0;
    end
    cap_if.cap_addr_we = 1'b1;
    cap_if.cap_addr_wdata = v.addr;
    cap_if.cap_flag_wdata = v.wr;
    if (v.same) begin
      cap_if.cap_data_we = 1'b1;
      cap_if.cap_data_wdata = v.wdata;
    end
    e.data = v.e_data; e.flag = v.e_flag; e.st = v.e_st; e.hold = v.e_hold;
    sb.push_back(e);
    tick();
    cap_if.cap_addr_we = 1'b0;
    cap_if.cap_data_we = 1'b0;
    chk($sformatf("v%0d_busy_on", idx), cap_if.cap_busy, 1);
    chk($sformatf("v%0d_flag_wr", idx), cap_if.cap_vpd_flag, v.wr);
    chk($sformatf("v%0d_cfg_addr", idx), cfg_if.cfg_vpd_addr, v.addr);
    if (v.wr)
      chk($sformatf("v%0d_cfg_wdata", idx), cfg_if.cfg_vpd_wdata, v.wdata);
    hold = 0; wrong = 0; ended = 0;
    for (int k = 1; k <= 60; k++) begin
      if (v.wr ? cfg_if.cfg_vpd_wren : cfg_if.cfg_vpd_rden) hold++;
      if (v.wr ? cfg_if.cfg_vpd_rden : cfg_if.cfg_vpd_wren) wrong++;
      if (k == v.dly) begin
        cfg_if.vpd_cfg_done = 1'b1;
        cfg_if.vpd_cfg_rdata = v.rdata;
        cfg_if.vpd_err_unimplemented_addr = v.err;
      end
      tick();
      cfg_if.vpd_cfg_done = 1'b0;
      cfg_if.vpd_err_unimplemented_addr = 1'b0;
      if (!cap_if.cap_busy) begin
        ended = 1;
        break;
      end
    end
    chk($sformatf("v%0d_completed", idx), ended, 1);
    e = sb.pop_front();
    chk($sformatf("v%0d_hold", idx), hold, e.hold);
    chk($sformatf("v%0d_wrong_req", idx), wrong, 0);
    chk($sformatf("v%0d_flag", idx), cap_if.cap_vpd_flag, e.flag);
    chk($sformatf("v%0d_data", idx), cap_if.cap_vpd_data, e.data);
    chk($sformatf("v%0d_status", idx), cap_if.cap_status, e.st);
    chk($sformatf("v%0d_req_off", idx),
        {cfg_if.cfg_vpd_rden, cfg_if.cfg_vpd_wren}, 0);
    if (e.st != 0) begin
      cap_if.cap_status_clr = 1'b1;
      tick();
      cap_if.cap_status_clr = 1'b0;
      chk($sformatf("v%0d_st_clr", idx), cap_if.cap_status, 0);
    end
  endtask

  initial begin
    vec_t tv;
    cap_if.cap_addr_we = 0; cap_if.cap_addr_wdata = 0;
    cap_if.cap_flag_wdata = 0; cap_if.cap_data_we = 0;
    cap_if.cap_data_wdata = 0; cap_if.cap_status_clr = 0;
    cfg_if.vpd_cfg_rdata = 0; cfg_if.vpd_cfg_done = 0;
    cfg_if.vpd_err_unimplemented_addr = 0;

    vecs.push_back(mk(0, 15'h0010, 0, 0, 5, 0, 32'hDEAD_BEEF,
                      32'hDEAD_BEEF, 1, 4'b0000, 5));
    vecs.push_back(mk(1, 15'h0200, 32'h1234_5678, 0, 3, 0, 0,
                      32'h1234_5678, 0, 4'b0000, 3));
    vecs.push_back(mk(1, 15'h0300, 32'hCAFE_F00D, 1, 1, 0, 0,
                      32'hCAFE_F00D, 0, 4'b0000, 1));
    vecs.push_back(mk(0, 15'h7FFF, 0, 0, 2, 1, 32'h0123_4567,
                      32'hFFFF_FFFF, 1, 4'b0001, 2));
    vecs.push_back(mk(1, 15'h0150, 32'h0BAD_C0DE, 0, 4, 1, 0,
                      32'h0BAD_C0DE, 0, 4'b0001, 4));
    vecs.push_back(mk(0, 15'h0001, 0, 0, TO, 0, 32'h5A5A_5A5A,
                      32'h5A5A_5A5A, 1, 4'b0000, TO));
`ifdef VPD_WRITE_PROTECT_EN
    vecs.push_back(mk(1, 15'h0040, 32'h7777_7777, 0, -1, 0, 0,
                      32'h7777_7777, 0, 4'b1000, 0));
    vecs.push_back(mk(1, 15'h0100, 32'h8888_8888, 0, 2, 0, 0,
                      32'h8888_8888, 0, 4'b0000, 2));
`else
    vecs.push_back(mk(1, 15'h0040, 32'h7777_7777, 0, 2, 0, 0,
                      32'h7777_7777, 0, 4'b0000, 2));
`endif

    #12;
    chk("rst_busy", cap_if.cap_busy, 0);
    chk("rst_flag", cap_if.cap_vpd_flag, 0);
    chk("rst_data", cap_if.cap_vpd_data, 0);
    chk("rst_addr", cap_if.cap_vpd_addr, 0);
    chk("rst_status", cap_if.cap_status, 0);
    chk("rst_req", {cfg_if.cfg_vpd_rden, cfg_if.cfg_vpd_wren}, 0);
    chk("rst_cfg_addr", cfg_if.cfg_vpd_addr, 0);
    chk("rst_cfg_wdata", cfg_if.cfg_vpd_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // timeout, then a stray done while idle
    tv = mk(0, 15'h0005, 0, 0, -1, 0, 0, 32'hFFFF_FFFF, 1, 4'b0010, TO);
    run_vec(tv, 100);
    cfg_if.vpd_cfg_done = 1'b1;
    cfg_if.vpd_cfg_rdata = 32'h1111_1111;
    cfg_if.vpd_err_unimplemented_addr = 1'b1;
    tick();
    cfg_if.vpd_cfg_done = 1'b0;
    cfg_if.vpd_err_unimplemented_addr = 1'b0;
    tick();
    chk("stray_data", cap_if.cap_vpd_data, 32'hFFFF_FFFF);
    chk("stray_status", cap_if.cap_status, 0);
    chk("stray_busy", cap_if.cap_busy, 0);
    chk("stray_flag", cap_if.cap_vpd_flag, 1);

    // busy violation, with a clear on the same cycle
    cap_if.cap_addr_we = 1'b1;
    cap_if.cap_addr_wdata = 15'h0010;
    cap_if.cap_flag_wdata = 1'b0;
    tick();
    cap_if.cap_addr_wdata = 15'h0020;
    cap_if.cap_flag_wdata = 1'b1;
    cap_if.cap_data_we = 1'b1;
    cap_if.cap_data_wdata = 32'h9999_9999;
    cap_if.cap_status_clr = 1'b1;
    tick();
    cap_if.cap_addr_we = 1'b0;
    cap_if.cap_data_we = 1'b0;
    cap_if.cap_status_clr = 1'b0;
    chk("viol_cfg_addr", cfg_if.cfg_vpd_addr, 15'h0010);
    chk("viol_rden", cfg_if.cfg_vpd_rden, 1);
    chk("viol_wren", cfg_if.cfg_vpd_wren, 0);
    chk("viol_status", cap_if.cap_status, 4'b0100);
    cfg_if.vpd_cfg_done = 1'b1;
    cfg_if.vpd_cfg_rdata = 32'h0BEE_F000;
    tick();
    cfg_if.vpd_cfg_done = 1'b0;
    chk("viol_done_data", cap_if.cap_vpd_data, 32'h0BEE_F000);
    chk("viol_done_flag", cap_if.cap_vpd_flag, 1);
    chk("viol_sticky", cap_if.cap_status, 4'b0100);
    cap_if.cap_status_clr = 1'b1;
    tick();
    cap_if.cap_status_clr = 1'b0;
    chk("viol_clr", cap_if.cap_status, 0);

    // asynchronous reset mid-request
    cap_if.cap_addr_we = 1'b1;
    cap_if.cap_addr_wdata = 15'h0030;
    cap_if.cap_flag_wdata = 1'b0;
    tick();
    cap_if.cap_addr_we = 1'b0;
    tick();
    chk("arst_pre_rden", cfg_if.cfg_vpd_rden, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rden", cfg_if.cfg_vpd_rden, 0);
    chk("arst_busy", cap_if.cap_busy, 0);
    chk("arst_addr", cfg_if.cfg_vpd_addr, 0);
    chk("arst_data", cap_if.cap_vpd_data, 0);
    chk("arst_flag", cap_if.cap_vpd_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
